// File: rtl/threshold_pair_stream.sv
// threshold_pair_stream
// Binarises RGB pixel pairs against a fixed grey-level threshold and emits
// them as a framed raster: start delay, active lines separated by an idle
// gap, and a one-cycle frame-done pulse that coincides with the last pair.
// Optional build macro: THRESHOLD_INVERT_EN swaps the output polarity, so hit
// pixels become black and non-hit pixels become white.
module threshold_pair_stream #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int THRESHOLD    = 90,
  parameter int START_DELAY  = 100,
  parameter int LINE_GAP     = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_Red_Even,
  input  logic [7:0] in_Green_Even,
  input  logic [7:0] in_Blue_Even,
  input  logic [7:0] in_Red_Odd,
  input  logic [7:0] in_Green_Odd,
  input  logic [7:0] in_Blue_Odd,
  output logic       horizontal_Pulse,
  output logic [7:0] data_Red_Even,
  output logic [7:0] data_Green_Even,
  output logic [7:0] data_Blue_Even,
  output logic [7:0] data_Red_Odd,
  output logic [7:0] data_Green_Odd,
  output logic [7:0] data_Blue_Odd,
  output logic       frame_Done,
  output logic       busy
);

  localparam int PAIRS    = IMAGE_WIDTH / 2;
  localparam int COL_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int WAIT_MAX = (START_DELAY > LINE_GAP) ? START_DELAY : LINE_GAP;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(PAIRS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [WAIT_W-1:0] WAIT_START = WAIT_W'(START_DELAY - 1);
  localparam logic [WAIT_W-1:0] WAIT_GAP   = WAIT_W'(LINE_GAP - 1);
  // 3*THRESHOLD fits in 10 bits for any 8-bit threshold, as does R+G+B.
  localparam logic [9:0]        THRESH3    = 10'(3 * THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              in_ready_q, in_ready_d;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  // All three channels of a result pixel are identical, so one byte each.
  logic [7:0]        even_q, even_d;
  logic [7:0]        odd_q, odd_d;
  logic              accept;

  // Grey-level test of one pixel; the sum is widened so 255*3 cannot wrap.
  function automatic logic [7:0] binarise(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
    logic [9:0] sum;
    logic       hit;
    sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    hit = (sum > THRESH3);
`ifdef THRESHOLD_INVERT_EN
    return hit ? 8'd0 : 8'd255;
`else
    return hit ? 8'd255 : 8'd0;
`endif
  endfunction

  // in_ready_q mirrors the ACTIVE state, so this is the full handshake.
  assign accept = in_valid & in_ready_q;

  // Next-state: frame sequencing, raster counters and result capture.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    col_d   = col_q;
    row_d   = row_q;
    pulse_d = 1'b0;
    even_d  = even_q;
    odd_d   = odd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DELAY;
          wait_d  = WAIT_START;
        end
      end
      S_DELAY: begin
        if (wait_q == '0) begin
          state_d = S_ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_GAP;
              wait_d  = WAIT_GAP;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (wait_q == '0) begin
          state_d = S_ACTIVE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      pulse_d = 1'b1;
      even_d  = binarise(in_Red_Even, in_Green_Even, in_Blue_Even);
      odd_d   = binarise(in_Red_Odd, in_Green_Odd, in_Blue_Odd);
    end

    // Status outputs are registered copies of the upcoming state.
    in_ready_d = (state_d == S_ACTIVE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers; reset clears everything, so an aborted
  // frame never produces frame_Done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      in_ready_q <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      even_q     <= 8'd0;
      odd_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      col_q      <= col_d;
      row_q      <= row_d;
      in_ready_q <= in_ready_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      even_q     <= even_d;
      odd_q      <= odd_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign horizontal_Pulse = pulse_q;
  assign frame_Done       = done_q;
  assign busy             = busy_q;
  assign data_Red_Even    = even_q;
  assign data_Green_Even  = even_q;
  assign data_Blue_Even   = even_q;
  assign data_Red_Odd     = odd_q;
  assign data_Green_Odd   = odd_q;
  assign data_Blue_Odd    = odd_q;

endmodule

// File: doc/threshold_pair_stream.md
# threshold_pair_stream

Upstream neighbour of the BMP writer. Accepts RGB pixel pairs (even/odd) from the image-memory reader over a valid/ready handshake and binarises each pixel against a fixed threshold. Emits the result as a raster with line framing: `horizontal_Pulse` marks active pixel pairs, there is a programmable start delay and inter-line gap, and a one-cycle frame-done pulse follows the last pair. Output ports connect one-to-one to the writer's pixel inputs.

## Interface
- `IMAGE_WIDTH`, 768: pixels per row; must be even. Pairs per row = IMAGE_WIDTH/2.
- `IMAGE_HEIGHT`, 512: rows per frame.
- `THRESHOLD`, 90: 8-bit grey-level threshold.
- `START_DELAY`, 100: idle cycles between start and the first line; minimum 1.
- `LINE_GAP`, 160: idle cycles between lines; minimum 1.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle frame request; honoured only in IDLE.
- `in_valid` in 1: input pair valid.
- `in_ready` out 1: block accepts a pair this cycle.
- `in_Red_Even`, `in_Green_Even`, `in_Blue_Even` in 8 each: even pixel.
- `in_Red_Odd`, `in_Green_Odd`, `in_Blue_Odd` in 8 each: odd pixel.
- `horizontal_Pulse` out 1: output pair valid.
- `data_Red_Even`, `data_Green_Even`, `data_Blue_Even` out 8 each: even result.
- `data_Red_Odd`, `data_Green_Odd`, `data_Blue_Odd` out 8 each: odd result.
- `frame_Done` out 1: one-cycle pulse after the last pair of the frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, DELAY, ACTIVE, GAP, DONE.
  - IDLE: goes to DELAY on `start`; wait counter loads START_DELAY-1.
  - DELAY: counts down; at 0 goes to ACTIVE; column and row counters cleared.
  - ACTIVE: `in_ready`=1. Each accepted pair (`in_valid & in_ready`) increments the column counter.
  - End of row: on acceptance of pair IMAGE_WIDTH/2-1, the column counter clears.
    - If it was the last row: go to DONE.
    - Otherwise: increment the row counter and go to GAP (counter loads LINE_GAP-1).
  - GAP: counts down; at 0 returns to ACTIVE.
  - DONE: `frame_Done`=1 for one cycle, then IDLE.
- Counters use $clog2 widths of their ranges. The column counter never exceeds IMAGE_WIDTH/2-1.
- Per-pixel arithmetic:
  - sum = R+G+B, computed in 10 bits unsigned.
  - hit = (sum > 3*THRESHOLD), with the comparison done in 10 bits.
  - All three output channels of the pixel = hit ? 8'd255 : 8'd0.
- Even and odd pixels are evaluated independently.
- `start` while not in IDLE is ignored. `in_valid` outside ACTIVE is ignored (`in_ready`=0).

## Timing
- Reset values: `in_ready`=0, `horizontal_Pulse`=0, all data outputs 0, `frame_Done`=0, `busy`=0, state IDLE, all counters 0.
- Latency: one cycle. A pair accepted in cycle n appears in cycle n+1 with `horizontal_Pulse`=1.
- `in_ready` is a registered function of state; it is high for every ACTIVE cycle.
- Stalls: an ACTIVE cycle with `in_valid`=0 produces `horizontal_Pulse`=0 in the next cycle. Data outputs hold their last value while `horizontal_Pulse`=0.
- Minimum frame length with no stalls: 1 + START_DELAY + IMAGE_HEIGHT·IMAGE_WIDTH/2 + (IMAGE_HEIGHT-1)·LINE_GAP + 1 cycles, from the `start` edge to `frame_Done`.
- Last pair: its `horizontal_Pulse` cycle coincides with `frame_Done` being asserted, since DONE is entered on the acceptance edge.
- `start` in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE begins a new frame.
- Reset mid-frame: all outputs return to reset values on the next edge, and no partial `frame_Done` is generated.

## Configuration
- `THRESHOLD_INVERT_EN` defined: hit pixels output 8'd0 and non-hit pixels output 8'd255.
- `THRESHOLD_INVERT_EN` undefined: polarity as specified in Operation.
- No other behaviour differs.

## Test plan
All scenarios use IMAGE_WIDTH=4, IMAGE_HEIGHT=2, START_DELAY=3, LINE_GAP=2, THRESHOLD=90.
- Frame, no stalls:
  - Stimulus: `start` at cycle 0, `in_valid` held at 1.
  - Expect `horizontal_Pulse` high for 2 cycles, low for 2 cycles, high for 2 cycles.
  - Expect `frame_Done` on the 4th pulse cycle and `busy` low the cycle after.
- Threshold boundary:
  - Stimulus: even pixel RGB = (90,90,90), sum 270; odd pixel RGB = (91,90,90), sum 271.
  - Expect even = 0,0,0 and odd = 255,255,255.
- Overflow guard:
  - Stimulus: RGB = (255,255,255).
  - Expect 255,255,255: the 765 sum must not wrap.
- Stall:
  - Stimulus: drop `in_valid` for 3 cycles mid-row.
  - Expect `horizontal_Pulse` low for exactly 3 cycles, the column count preserved, and still exactly 4 pulses per frame.
- Reset and restart:
  - Stimulus: `reset` asserted during the second line.
  - Expect all outputs 0 on the next edge and no `frame_Done`; a following `start` produces a complete frame.
  - Stimulus: `start` during GAP. Expect it to be ignored.
- Inversion:
  - Stimulus: rerun the threshold-boundary case with `THRESHOLD_INVERT_EN` defined.
  - Expect even = 255,255,255 and odd = 0,0,0.
